// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU step/run clock-enable logic.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        STEP  = 2'd0,
        RUN   = 2'd1,
        BREAK = 2'd2
    } step_state_e;

    localparam int STEP_COUNT_W        = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
    localparam int DEF_RUN_DIV         = 50000000;  // 1 Hz auto-run at 50 MHz

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// RST_VAL is the level the synchronizer and the accepted output take in reset.
module debounce_sync
    import cpu_dbg_pkg::*;
#(
    parameter int   DEB_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int             CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A differing sample must persist DEB_CYCLES samples in a row to be accepted.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer, accepted level and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step / auto-run clock-enable generator for the single-cycle core.
// Optional breakpoint support is compiled in with `define CPU_STEP_CTRL_BREAK_EN.
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    KEY_STEP,
    input  logic                    SW_RUN,
`ifdef CPU_STEP_CTRL_BREAK_EN
    input  logic [31:0]             PC,
    input  logic [31:0]             BREAK_PC,
    output logic                    BREAK_HIT,
`endif
    output logic                    STEP_EN,
    output logic [STEP_COUNT_W-1:0] STEP_COUNT,
    output logic                    RUN_MODE
);

    localparam int            DW       = $clog2(RUN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

    logic stable_key, stable_run, press;

    step_state_e             state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic                    step_en_q, step_en_d;
    logic [STEP_COUNT_W-1:0] step_count_q, step_count_d;
    logic                    run_mode_q, run_mode_d;
    logic                    key_prev_q, key_prev_d;
`ifdef CPU_STEP_CTRL_BREAK_EN
    logic                    break_hit_q, break_hit_d;
`endif

    // Key idles released (high), switch idles in single-step (low).
    debounce_sync #(.DEB_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_key_db (
        .clk (CLK), .rst_n (RST), .din (KEY_STEP), .dout (stable_key)
    );
    debounce_sync #(.DEB_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_run_db (
        .clk (CLK), .rst_n (RST), .din (SW_RUN), .dout (stable_run)
    );

    // Press is the falling edge of the accepted key level; release is ignored.
    assign press = key_prev_q & ~stable_key;

    // Next-state, divider and strobe; a mode change always beats a strobe.
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        step_en_d  = 1'b0;
        key_prev_d = stable_key;
        case (state_q)
            STEP: begin
                if (stable_run) begin
                    state_d = RUN;
                end else if (press) begin
                    step_en_d = 1'b1;
                end
            end
            RUN: begin
                if (!stable_run) begin
                    state_d = STEP;
                end else if (div_q == DIV_LAST) begin
`ifdef CPU_STEP_CTRL_BREAK_EN
                    if (PC == BREAK_PC) begin
                        state_d = BREAK;
                    end else begin
                        step_en_d = 1'b1;
                    end
`else
                    step_en_d = 1'b1;
`endif
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`ifdef CPU_STEP_CTRL_BREAK_EN
            BREAK: begin
                if (!stable_run) begin
                    state_d = STEP;
                end
            end
`endif
            default: state_d = STEP;
        endcase
        step_count_d = step_count_q + {{(STEP_COUNT_W-1){1'b0}}, step_en_d};
        run_mode_d   = (state_d == RUN);
`ifdef CPU_STEP_CTRL_BREAK_EN
        break_hit_d  = (state_d == BREAK);
`endif
    end

    // State, divider and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= STEP;
            div_q        <= '0;
            step_en_q    <= 1'b0;
            step_count_q <= '0;
            run_mode_q   <= 1'b0;
            key_prev_q   <= 1'b1;
`ifdef CPU_STEP_CTRL_BREAK_EN
            break_hit_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            step_en_q    <= step_en_d;
            step_count_q <= step_count_d;
            run_mode_q   <= run_mode_d;
            key_prev_q   <= key_prev_d;
`ifdef CPU_STEP_CTRL_BREAK_EN
            break_hit_q  <= break_hit_d;
`endif
        end
    end

    assign STEP_EN    = step_en_q;
    assign STEP_COUNT = step_count_q;
    assign RUN_MODE   = run_mode_q;
`ifdef CPU_STEP_CTRL_BREAK_EN
    assign BREAK_HIT  = break_hit_q;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=8).
// Expected strobes are derived from input waveforms at the level of
// "accepted level changes" and "run intervals", queued, and matched by a monitor.
module tb_cpu_step_ctrl;

    localparam int DEB  = 4;
    localparam int RDIV = 8;
    localparam int MAXN = 1023;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        KEY_STEP = 1'b1;
    logic        SW_RUN = 1'b0;
    logic        STEP_EN;
    logic [15:0] STEP_COUNT;
    logic        RUN_MODE;
`ifdef CPU_STEP_CTRL_BREAK_EN
    logic [31:0] PC = 32'h0;
    logic [31:0] BREAK_PC = 32'hFFFF_FFFF;
    logic        BREAK_HIT;
`endif

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(RDIV)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KEY_STEP   (KEY_STEP),
        .SW_RUN     (SW_RUN),
`ifdef CPU_STEP_CTRL_BREAK_EN
        .PC         (PC),
        .BREAK_PC   (BREAK_PC),
        .BREAK_HIT  (BREAK_HIT),
`endif
        .STEP_EN    (STEP_EN),
        .STEP_COUNT (STEP_COUNT),
        .RUN_MODE   (RUN_MODE)
    );

    always #5 CLK = ~CLK;

    typedef struct { int at; logic [15:0] cnt; } exp_t;
    exp_t exp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          base = 0;
    int          n_cur = 0;
    bit          mon_en = 1'b0;
    bit          cnt_pend = 1'b0;
    logic [15:0] cnt_pend_val = '0;
    logic [15:0] mcnt = '0;
    int          mon_e;
    exp_t        mon_ev;

    bit key_raw [0:MAXN];
    bit run_raw [0:MAXN];
    bit stk     [0:MAXN];
    bit str     [0:MAXN];
    bit strb    [0:MAXN];
    bit rm_exp  [0:MAXN];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every strobe, checks count a cycle later.
    always @(negedge CLK) begin
        if (mon_en) begin
            mon_e = cyc - base;
            if (cnt_pend) begin
                check("step_count", {16'h0, STEP_COUNT}, {16'h0, cnt_pend_val});
                cnt_pend = 1'b0;
            end
            if (mon_e >= 1 && mon_e <= n_cur)
                check("run_mode", {31'h0, RUN_MODE}, {31'h0, rm_exp[mon_e]});
            if (mon_e >= 1 && STEP_EN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got strobe at edge %0d expected none", mon_e);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("strobe_edge", mon_e, mon_ev.at);
                    cnt_pend     = 1'b1;
                    cnt_pend_val = mon_ev.cnt;
                end
            end
        end
    end

    task automatic clear_stim();
        for (int i = 0; i <= MAXN; i++) begin
            key_raw[i] = 1'b1;
            run_raw[i] = 1'b0;
        end
    endtask

    // Accepted level: a run of DEB or more edges at a new level is taken
    // DEB+1 edges after it starts; st[t] is the accepted level after edge t.
    task automatic calc_stable(input bit is_run, input int n);
        bit raw [0:MAXN];
        bit st  [0:MAXN];
        bit cur;
        int t, len;
        for (int i = 0; i <= MAXN; i++) raw[i] = is_run ? run_raw[i] : key_raw[i];
        cur = is_run ? 1'b0 : 1'b1;
        for (int i = 0; i <= MAXN; i++) st[i] = cur;
        t = 1;
        while (t <= n) begin
            if (raw[t] != cur) begin
                len = 0;
                while (t + len <= n && raw[t + len] == raw[t]) len++;
                if (len >= DEB) begin
                    cur = raw[t];
                    for (int k = t + DEB + 1; k <= MAXN; k++) st[k] = cur;
                end
                t += len;
            end else begin
                t++;
            end
        end
        for (int i = 0; i <= MAXN; i++) begin
            if (is_run) str[i] = st[i];
            else        stk[i] = st[i];
        end
    endtask

    // Expected strobes: presses only while the switch is off and was off the
    // edge before; in run, every RDIV edges after entry until the switch drops.
    task automatic model_phase(input int n);
        int q;
        calc_stable(1'b0, n);
        calc_stable(1'b1, n);
        for (int i = 0; i <= MAXN; i++) strb[i] = 1'b0;
        rm_exp[0] = 1'b0;
        for (int e = 1; e <= MAXN; e++) rm_exp[e] = str[e-1];
        for (int f = 1; f < MAXN; f++)
            if (stk[f-1] && !stk[f] && !str[f-1] && !str[f]) strb[f+1] = 1'b1;
        for (int r = 1; r < MAXN; r++) begin
            if (!str[r-1] && str[r]) begin
                q = r;
                while (q < MAXN && str[q]) q++;
                for (int e = r + 1 + RDIV; e <= q; e += RDIV) strb[e] = 1'b1;
            end
        end
        for (int e = 1; e <= MAXN; e++) begin
            if (strb[e]) begin
                mcnt = mcnt + 16'd1;
                exp_q.push_back('{at: e, cnt: mcnt});
            end
        end
    endtask

    // Called right after a negedge; edge 1 is the next rising edge.
    task automatic run_phase(input string name, input int n);
        model_phase(n);
        base  = cyc;
        n_cur = n;
        mon_en = 1'b1;
        for (int t = 1; t <= n; t++) begin
            KEY_STEP = key_raw[t];
            SW_RUN   = run_raw[t];
            @(negedge CLK);
        end
        KEY_STEP = 1'b1;
        SW_RUN   = 1'b0;
        repeat (2) @(negedge CLK);
        mon_en = 1'b0;
        check({name, "_missing_strobes"}, exp_q.size(), 0);
        check({name, "_final_count"}, {16'h0, STEP_COUNT}, {16'h0, mcnt});
        check({name, "_final_run_mode"}, {31'h0, RUN_MODE}, 32'h0);
        exp_q.delete();
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        KEY_STEP = 1'b1;
        SW_RUN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        mcnt = '0;
    endtask

    task automatic gen_random(input int nbody);
        int t, len;
        bit lvl;
        clear_stim();
        lvl = 1'b1;
        t = 1;
        while (t <= nbody) begin
            len = $urandom_range(1, 12);
            for (int k = 0; k < len && t <= nbody; k++) begin key_raw[t] = lvl; t++; end
            lvl = !lvl;
        end
        lvl = 1'b0;
        t = 1;
        while (t <= nbody) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 80);
            for (int k = 0; k < len && t <= nbody; k++) begin run_raw[t] = lvl; t++; end
            lvl = !lvl;
        end
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("reset_step_en", {31'h0, STEP_EN}, 32'h0);
        check("reset_step_count", {16'h0, STEP_COUNT}, 32'h0);
        check("reset_run_mode", {31'h0, RUN_MODE}, 32'h0);
        RST = 1'b1;

        // single press: key low 20 cycles, one strobe 7 edges after the fall
        clear_stim();
        for (int t = 1; t <= 20; t++) key_raw[t] = 1'b0;
        run_phase("single_press", 60);

        // glitch: 3 cycles low is too short
        clear_stim();
        for (int t = 1; t <= 3; t++) key_raw[t] = 1'b0;
        run_phase("glitch", 40);

        // auto-run with presses that must be ignored
        clear_stim();
        for (int t = 1; t <= 100; t++) run_raw[t] = 1'b1;
        for (int t = 30; t <= 40; t++) key_raw[t] = 1'b0;
        for (int t = 60; t <= 70; t++) key_raw[t] = 1'b0;
        run_phase("auto_run", 140);

        // counter wrap
        force dut.step_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.step_count_q;
        mcnt = 16'hFFFF;
        clear_stim();
        for (int t = 1; t <= 10; t++) key_raw[t] = 1'b0;
        run_phase("wrap", 50);

        // one more press so the count is nonzero before the mid-debounce reset
        clear_stim();
        for (int t = 1; t <= 8; t++) key_raw[t] = 1'b0;
        run_phase("pre_reset", 40);

        // reset while the key counter sits at 2
        KEY_STEP = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midreset_step_en", {31'h0, STEP_EN}, 32'h0);
        check("midreset_step_count", {16'h0, STEP_COUNT}, 32'h0);
        check("midreset_run_mode", {31'h0, RUN_MODE}, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        mcnt = '0;
        clear_stim();
        for (int t = 1; t <= 12; t++) key_raw[t] = 1'b0;
        run_phase("after_reset", 52);

        // randomized waveforms on both inputs
        for (int r = 0; r < 3; r++) begin
            gen_random(600);
            run_phase("random", 640);
        end

`ifdef CPU_STEP_CTRL_BREAK_EN
        begin
            int ns;
            bit hit;
            apply_reset();
            BREAK_PC = 32'h10;
            PC = 32'h0;
            SW_RUN = 1'b1;
            ns = 0;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge CLK);
                if (STEP_EN === 1'b1) begin ns++; PC = PC + 32'd4; end
                if (BREAK_HIT === 1'b1) hit = 1'b1;
            end
            check("break_hit", {31'h0, BREAK_HIT}, 32'h1);
            check("break_strobes", ns, 4);
            check("break_pc", PC, 32'h10);
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                if (STEP_EN === 1'b1) ns++;
            end
            check("break_no_strobe", ns, 4);
            SW_RUN = 1'b0;
            repeat (10) @(negedge CLK);
            check("break_cleared", {31'h0, BREAK_HIT}, 32'h0);
            check("break_run_mode", {31'h0, RUN_MODE}, 32'h0);
            BREAK_PC = 32'hFFFF_FFFF;
        end
`else
        apply_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
